// File: rtl/lpt_capture_port_if.sv
// lpt_capture_port_if: chipset I/O bus plus sink byte stream for the LPT capture port
interface lpt_capture_port_if;
    logic [19:0] address;
    logic        address_enable_n;
    logic        io_read_n;
    logic        io_write_n;
    logic [7:0]  data_bus;
    logic [7:0]  data_bus_out;
    logic        data_bus_out_valid;
    logic        irq;
    logic [7:0]  sink_data;
    logic        sink_valid;
    logic        sink_ready;
    modport master (
        output address, address_enable_n, io_read_n, io_write_n, data_bus, sink_ready,
        input  data_bus_out, data_bus_out_valid, irq, sink_data, sink_valid
    );
    modport slave (
        input  address, address_enable_n, io_read_n, io_write_n, data_bus, sink_ready,
        output data_bus_out, data_bus_out_valid, irq, sink_data, sink_valid
    );
endinterface

// File: rtl/lpt_capture_port.sv
// lpt_capture_port: LPT1-style register set turning STROBE handshakes into a FIFO-buffered byte stream
module lpt_capture_port #(
    parameter logic [9:0] BASE_ADDR  = 10'h378,
    parameter int          FIFO_AW    = 4,
    parameter int          ACK_CYCLES = 16
) (
    input logic clock,
    input logic reset,
    lpt_capture_port_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW = $clog2(ACK_CYCLES + 1);

    logic [9:0]         offset;
    logic [1:0]         idx, wr_idx_q;
    logic               sel, unused_addr;
    logic [7:0]         data_q, wr_data_q, status;
    logic [4:0]         ctrl_q;
    logic               wr_pend_q, rd_stat_q, irq_q, nerror_q;
    logic [CW-1:0]      ack_cnt_q;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wp_q, rp_q;
    logic [FIFO_AW:0]   count_q;
    logic               commit, ctrl_wr, strobe, full, push, drop, pop, flush, stat_done, irq_clr, ack_active;

    assign unused_addr = ^bus.address[19:10];
    // Unsigned wrap makes addresses below BASE land far above 2
    assign offset = bus.address[9:0] - BASE_ADDR;
    assign sel    = ~bus.address_enable_n & (offset < 10'd3);
    assign idx    = offset[1:0];

    assign ack_active = ack_cnt_q != '0;
    assign full       = count_q[FIFO_AW];
    assign status     = {~(ack_active | full), ~ack_active, 1'b0, 1'b1, nerror_q, 3'b111};

    assign bus.data_bus_out_valid = sel & ~bus.io_read_n;
    assign bus.data_bus_out = !bus.data_bus_out_valid ? 8'h00 :
                              idx == 2'd0 ? data_q :
                              idx == 2'd1 ? status : {3'b111, ctrl_q};

    assign commit    = wr_pend_q & bus.io_write_n;
    assign ctrl_wr   = commit & (wr_idx_q == 2'd2);
    assign strobe    = ctrl_wr & wr_data_q[0] & ~ctrl_q[0];
    assign push      = strobe & ~full;
    assign drop      = strobe & full;
    assign flush     = ctrl_wr & ~wr_data_q[2];
    assign pop       = bus.sink_valid & bus.sink_ready;
    assign stat_done = rd_stat_q & bus.io_read_n & sel & (idx == 2'd1);
    assign irq_clr   = stat_done | (ctrl_wr & ~wr_data_q[4]);

    assign bus.irq        = irq_q;
    assign bus.sink_valid = count_q != '0;
    assign bus.sink_data  = mem[rp_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q    <= 8'h00;
            ctrl_q    <= 5'b00100;
            wr_data_q <= 8'h00;
            wr_idx_q  <= 2'd0;
            wr_pend_q <= 1'b0;
            rd_stat_q <= 1'b0;
            irq_q     <= 1'b0;
            nerror_q  <= 1'b1;
            ack_cnt_q <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
        end else begin
            rd_stat_q <= sel & ~bus.io_read_n & (idx == 2'd1);
            if (sel & ~bus.io_write_n) begin
                wr_data_q <= bus.data_bus;
                wr_idx_q  <= idx;
            end
            // Pending survives an address change until the strobe goes high
            wr_pend_q <= (sel | wr_pend_q) & ~bus.io_write_n;
            if (commit & (wr_idx_q == 2'd0))
                data_q <= wr_data_q;
            if (ctrl_wr)
                ctrl_q <= wr_data_q[4:0];
            if (push)
                ack_cnt_q <= CW'(ACK_CYCLES);
            else if (ack_active)
                ack_cnt_q <= ack_cnt_q - CW'(1);
            irq_q    <= (push & wr_data_q[4]) | (irq_q & ~irq_clr);
            nerror_q <= flush | (nerror_q & ~drop);
            if (flush) begin
                wp_q    <= '0;
                rp_q    <= '0;
                count_q <= '0;
            end else begin
                if (push)
                    wp_q <= wp_q + FIFO_AW'(1);
                if (pop)
                    rp_q <= rp_q + FIFO_AW'(1);
                count_q <= count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clock)
        if (push)
            mem[wp_q] <= data_q;
endmodule

// File: tb/tb_lpt_capture_port.sv
// tb_lpt_capture_port: directed plus randomized checks against a queue-based printer port model
module tb_lpt_capture_port;
    localparam logic [9:0] BASE = 10'h378;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] q[$];
    bit irq_m = 1'b0;
    bit nerror_m = 1'b1;
    logic [7:0] rd;
    logic rv;
    int lows;

    lpt_capture_port_if bus ();
    lpt_capture_port #(.BASE_ADDR(BASE), .FIFO_AW(4), .ACK_CYCLES(16)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [7:0] d, input logic aen);
        @(negedge clock);
        bus.address = {10'h000, a};
        bus.address_enable_n = aen;
        bus.data_bus = d;
        bus.io_write_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        bus.io_write_n = 1'b1;
        @(negedge clock);
        bus.address_enable_n = 1'b1;
    endtask

    task automatic bus_read(input logic [9:0] a, input logic aen, output logic [7:0] d, output logic v);
        @(negedge clock);
        bus.address = {10'h000, a};
        bus.address_enable_n = aen;
        bus.io_read_n = 1'b0;
        #1;
        d = bus.data_bus_out;
        v = bus.data_bus_out_valid;
        @(negedge clock);
        bus.io_read_n = 1'b1;
        @(negedge clock);
        bus.address_enable_n = 1'b1;
    endtask

    // Model: a strobe queues the byte when under 16 held, else flags an error
    task automatic strobe(input logic [7:0] d, input bit ien);
        bus_write(BASE, d, 1'b0);
        bus_write(BASE + 10'd2, {3'b000, ien, 4'b0101}, 1'b0);
        bus_write(BASE + 10'd2, {3'b000, ien, 4'b0100}, 1'b0);
        if (q.size() < 16) begin
            q.push_back(d);
            if (ien) irq_m = 1'b1;
        end else
            nerror_m = 1'b0;
        if (!ien) irq_m = 1'b0;
    endtask

    task automatic drain(input int cycles, input bit rnd);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            bus.sink_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk("sink_valid", bus.sink_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("sink_data", bus.sink_data, q[0]);
                if (bus.sink_ready) q.delete(0);
            end
        end
        @(negedge clock);
        bus.sink_ready = 1'b0;
    endtask

    task automatic chk_sink(input string tag);
        chk({tag, "_valid"}, bus.sink_valid, q.size() != 0);
        if (q.size() != 0) chk({tag, "_data"}, bus.sink_data, q[0]);
    endtask

    initial begin
        bus.address = '0;
        bus.address_enable_n = 1'b1;
        bus.io_read_n = 1'b1;
        bus.io_write_n = 1'b1;
        bus.data_bus = 8'h00;
        bus.sink_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        chk("rst_irq", bus.irq, 1'b0);
        chk("rst_sink_valid", bus.sink_valid, 1'b0);
        chk("rst_dbo", bus.data_bus_out, 8'h00);
        chk("rst_dbo_valid", bus.data_bus_out_valid, 1'b0);
        bus_read(BASE + 10'd1, 1'b0, rd, rv);
        chk("rst_status", rd, 8'hDF);
        chk("rst_status_valid", rv, 1'b1);
        bus_read(BASE + 10'd2, 1'b0, rd, rv);
        chk("rst_control", rd, 8'hE4);
        bus_read(BASE, 1'b0, rd, rv);
        chk("rst_data", rd, 8'h00);

        bus_write(BASE, 8'h41, 1'b0);
        bus_write(BASE + 10'd2, 8'h15, 1'b0);
        q.push_back(8'h41);
        bus.address = {10'h000, BASE + 10'd1};
        bus.address_enable_n = 1'b0;
        bus.io_read_n = 1'b0;
        lows = 0;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (!bus.data_bus_out[6]) lows++;
            if (i == 2) begin
                chk("pulse_busy", bus.data_bus_out[7], 1'b0);
                chk("pulse_irq", bus.irq, 1'b1);
                chk_sink("first_push");
            end
            @(negedge clock);
        end
        chk("nack_width", lows, 16);
        bus.io_read_n = 1'b1;
        @(negedge clock);
        bus.address_enable_n = 1'b1;
        chk("irq_cleared_by_status", bus.irq, 1'b0);
        bus_write(BASE + 10'd2, 8'h14, 1'b0);
        chk("irq_stays_clear", bus.irq, 1'b0);
        chk_sink("after_release");
        drain(3, 1'b0);

        for (int i = 0; i < 17; i++) strobe(8'(i), 1'b0);
        chk("full_q_size", q.size(), 16);
        bus_read(BASE + 10'd1, 1'b0, rd, rv);
        chk("full_nerror", rd[3], 1'b0);
        chk("full_busy", rd[7], 1'b0);
        drain(20, 1'b0);

        strobe(8'hA1, 1'b0);
        strobe(8'hA2, 1'b0);
        chk("preflush_valid", bus.sink_valid, 1'b1);
        bus_write(BASE + 10'd2, 8'h10, 1'b0);
        bus_write(BASE + 10'd2, 8'h14, 1'b0);
        q.delete();
        nerror_m = 1'b1;
        chk("flush_empty", bus.sink_valid, 1'b0);
        bus_read(BASE + 10'd1, 1'b0, rd, rv);
        chk("flush_nerror", rd[3], 1'b1);

        bus_write(BASE, 8'h5A, 1'b0);
        bus_write(BASE, 8'hAA, 1'b1);
        bus_read(BASE, 1'b0, rd, rv);
        chk("dma_write_ignored", rd, 8'h5A);
        bus_read(BASE, 1'b1, rd, rv);
        chk("dma_read_valid", rv, 1'b0);
        bus_read(10'h3F8, 1'b0, rd, rv);
        chk("other_port_valid", rv, 1'b0);
        chk("other_port_data", rd, 8'h00);

        bus_write(BASE, 8'h77, 1'b0);
        bus_write(BASE + 10'd2, 8'h15, 1'b0);
        chk("prereset_irq", bus.irq, 1'b1);
        chk("prereset_valid", bus.sink_valid, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        irq_m = 1'b0;
        nerror_m = 1'b1;
        chk("midreset_irq", bus.irq, 1'b0);
        chk("midreset_valid", bus.sink_valid, 1'b0);
        bus_read(BASE + 10'd1, 1'b0, rd, rv);
        chk("midreset_status", rd, 8'hDF);
        bus_read(BASE + 10'd2, 1'b0, rd, rv);
        chk("midreset_control", rd, 8'hE4);
        bus_read(BASE, 1'b0, rd, rv);
        chk("midreset_data", rd, 8'h00);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) != 2) strobe(8'($urandom), 1'($urandom_range(0, 1)));
            else drain($urandom_range(1, 8), 1'b1);
            chk("rnd_irq", bus.irq, irq_m);
            chk_sink("rnd_sink");
            bus_read(BASE + 10'd1, 1'b0, rd, rv);
            chk("rnd_nerror", rd[3], nerror_m);
            irq_m = 1'b0;
            chk("rnd_irq_after_status", bus.irq, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
